amba_dpcm_decoder_saturation: RTL and testbench

APB slave that reconstructs 8-bit samples from DPCM difference codes written by a bus master. Each difference is added to the running predictor and the sum is saturated. The result is pushed into a small sample FIFO that the master drains over APB. This block is the receive-side counterpart to the DPCM saturating encoder, and is fed by the encoder's difference stream.

---
 rtl/amba_dpcm_decoder_saturation_if.sv | 24 ++
 rtl/amba_dpcm_decoder_saturation.sv | 210 +++++++++++++++++++++
 tb/tb_amba_dpcm_decoder_saturation.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/amba_dpcm_decoder_saturation_if.sv
// APB-style bus bundle for the DPCM decoder: master drives the request, slave returns
// registered read data, ready and error.
interface amba_dpcm_decoder_saturation_if #(
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [3:0]        paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba_dpcm_decoder_saturation.sv
// APB DPCM decoder: each DIFF write adds to the predictor and queues the sample for
// SAMPLE reads. Define DPCM_SATURATION_EN to clamp the sum; otherwise it wraps.
module amba_dpcm_decoder_saturation #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic clk,
    input  logic reset,
    amba_dpcm_decoder_saturation_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // state_reg names the bus phase most recently sampled at a rising edge
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_POP   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

    logic [1:0]        state_reg;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] pred_reg;
    logic [DATA_W-1:0] sum_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] prdata_reg;
    logic              pready_reg;
    logic              pslverr_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              access;
    logic              full;
    logic              empty;
    logic [3:0]        cnt4;
    logic [DATA_W-1:0] status_val;
    logic signed [DATA_W:0] sum_wide;
    logic [DATA_W-1:0] sum_next;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_op;
    logic              commit;
    logic [1:0]        unused_addr_bits;

    assign unused_addr_bits = bus.paddr[1:0];

    assign access = bus.psel & bus.penable;
    assign full   = (count_reg == CW'(FIFO_DEPTH));
    assign empty  = (count_reg == '0);
    assign cnt4   = 4'(count_reg);
    assign commit = (state_reg == S_WAIT) && access;

    assign sum_wide = $signed({pred_reg[DATA_W-1], pred_reg})
                    + $signed({bus.pwdata[DATA_W-1], bus.pwdata});

    always_comb begin
`ifdef DPCM_SATURATION_EN
        if (sum_wide > SAT_MAX) begin
            sum_next = SAT_MAX[DATA_W-1:0];
        end else if (sum_wide < SAT_MIN) begin
            sum_next = SAT_MIN[DATA_W-1:0];
        end else begin
            sum_next = sum_wide[DATA_W-1:0];
        end
`else
        sum_next = sum_wide[DATA_W-1:0];
`endif
    end

    always_comb begin
        status_val      = '0;
        status_val[7:4] = cnt4;
        status_val[1]   = full;
        status_val[0]   = empty;
    end

    // Response is decided in the first access cycle and committed one cycle later
    always_comb begin
        resp_err  = 1'b0;
        resp_data = '0;
        resp_op   = OP_NONE;
        case (bus.paddr[3:2])
            2'd0: begin
                if (!bus.pwrite || full) begin
                    resp_err = 1'b1;
                end else begin
                    resp_op = OP_PUSH;
                end
            end
            2'd1: begin
                if (bus.pwrite || empty) begin
                    resp_err = 1'b1;
                end else begin
                    resp_data = rd_data_reg;
                    resp_op   = OP_POP;
                end
            end
            2'd2: begin
                if (bus.pwrite) begin
                    resp_err = 1'b1;
                end else begin
                    resp_data = status_val;
                end
            end
            default: begin
                if (!bus.pwrite) begin
                    resp_err = 1'b1;
                end else if (bus.pwdata[0]) begin
                    resp_op = OP_CLEAR;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_NONE;
            pred_reg    <= '0;
            sum_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            pready_reg  <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
            case (state_reg)
                S_SETUP: begin
                    if (access) begin
                        state_reg   <= S_WAIT;
                        pready_reg  <= 1'b1;
                        prdata_reg  <= resp_data;
                        pslverr_reg <= resp_err;
                        op_reg      <= resp_op;
                        sum_reg     <= sum_next;
                    end else if (bus.psel) begin
                        state_reg <= S_SETUP;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (access) begin
                        state_reg <= S_RESP;
                    end else if (bus.psel) begin
                        state_reg <= S_SETUP;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                    if (commit) begin
                        case (op_reg)
                            OP_PUSH: begin
                                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                                count_reg  <= count_reg + CW'(1);
                                pred_reg   <= sum_reg;
                            end
                            OP_POP: begin
                                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                                count_reg  <= count_reg - CW'(1);
                            end
                            OP_CLEAR: begin
                                wr_ptr_reg <= '0;
                                rd_ptr_reg <= '0;
                                count_reg  <= '0;
                                pred_reg   <= '0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    // IDLE and RESP both accept a fresh setup phase
                    if (bus.psel && !bus.penable) begin
                        state_reg <= S_SETUP;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Sample storage: plain array with registered read of the current head
    always_ff @(posedge clk) begin
        if (!reset && commit && (op_reg == OP_PUSH)) begin
            mem[wr_ptr_reg] <= sum_reg;
        end
        rd_data_reg <= mem[rd_ptr_reg];
    end

    assign bus.prdata  = prdata_reg;
    assign bus.pready  = pready_reg;
    assign bus.pslverr = pslverr_reg;

endmodule

// File: tb/tb_amba_dpcm_decoder_saturation.sv
// Bench for the APB DPCM decoder: queue-based reference model, per-cycle idle-output
// monitor, hand-computed anchor cases and a randomized transfer mix.
module tb_amba_dpcm_decoder_saturation;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic prev_pready;

    amba_dpcm_decoder_saturation_if #(.DATA_W(8)) bus ();

    amba_dpcm_decoder_saturation #(
        .FIFO_DEPTH(DEPTH),
        .DATA_W    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: the queued samples and the running predictor
    logic [7:0] q[$];
    int         pred;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] recon(input int p, input logic [7:0] d);
        int s;
        s = p + int'($signed(d));
`ifdef DPCM_SATURATION_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return 8'(s);
    endfunction

    task automatic model(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                         output logic [7:0] erd, output logic eer);
        logic [7:0] v;
        erd = 8'h00;
        eer = 1'b0;
        case (a[3:2])
            2'd0: begin
                if (!wr || q.size() == DEPTH) begin
                    eer = 1'b1;
                end else begin
                    v = recon(pred, wd);
                    q.push_back(v);
                    pred = int'($signed(v));
                end
            end
            2'd1: begin
                if (wr || q.size() == 0) eer = 1'b1;
                else erd = q.pop_front();
            end
            2'd2: begin
                if (wr) eer = 1'b1;
                else erd = {4'(q.size()), 2'b00, q.size() == DEPTH, q.size() == 0};
            end
            default: begin
                if (!wr) begin
                    eer = 1'b1;
                end else if (wd[0]) begin
                    q.delete();
                    pred = 0;
                end
            end
        endcase
    endtask

    task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic er);
        int waits;
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = wd;
        @(negedge clk);
        chk("setup_pready", {31'd0, bus.pready}, 32'd0);
        bus.penable = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.pready && waits < 6) begin
            waits++;
            @(negedge clk);
        end
        chk("resp_latency", waits, 0);
        rd = bus.prdata;
        er = bus.pslverr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
        end
    endtask

    task automatic do_op(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                         output logic [7:0] rd, output logic er);
        logic [7:0] erd;
        logic       eer;
        model(wr, a, wd, erd, eer);
        xfer(wr, a, wd, rd, er);
        chk("pslverr", {31'd0, er}, {31'd0, eer});
        if (!wr) chk("prdata", {24'd0, rd}, {24'd0, erd});
        $display("xfer %s addr=%h wdata=%h rdata=%h err=%0d exp_rdata=%h exp_err=%0d",
                 wr ? "WR" : "RD", a, wd, rd, er, erd, eer);
    endtask

    // Outside RESP the registered outputs must be zero and ready never lasts two cycles
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.pready) begin
                chk("idle_prdata", {24'd0, bus.prdata}, 32'd0);
                chk("idle_pslverr", {31'd0, bus.pslverr}, 32'd0);
            end else begin
                chk("pready_single", {31'd0, prev_pready}, 32'd0);
            end
        end
        prev_pready = bus.pready;
    end

    logic [7:0] rd;
    logic       er;

    initial begin
        total = 0;
        bad = 0;
        prev_pready = 1'b0;
        pred = 0;
        reset = 1'b1;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite = 1'b0;
        bus.paddr = 4'h0;
        bus.pwdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pready", {31'd0, bus.pready}, 32'd0);
        chk("rst_prdata", {24'd0, bus.prdata}, 32'd0);
        chk("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        reset = 1'b0;
        idle(1);

        do_op(1'b0, 4'h8, 8'h00, rd, er);
        chk("lit_status_empty", {24'd0, rd}, 32'h01);
        chk("lit_status_err", {31'd0, er}, 32'd0);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
        chk("lit_pop_empty_err", {31'd0, er}, 32'd1);
        chk("lit_pop_empty_data", {24'd0, rd}, 32'd0);

        do_op(1'b1, 4'h0, 8'd100, rd, er);
        do_op(1'b1, 4'h0, 8'd100, rd, er);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
        chk("lit_s1", {24'd0, rd}, 32'd100);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
`ifdef DPCM_SATURATION_EN
        chk("lit_s2_sat", {24'd0, rd}, 32'h7F);
`else
        chk("lit_s2_wrap", {24'd0, rd}, 32'hC8);
`endif
        idle(2);

        do_op(1'b1, 4'hC, 8'h01, rd, er);
        do_op(1'b1, 4'h0, 8'd127, rd, er);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
        chk("lit_pred127", {24'd0, rd}, 32'h7F);
        do_op(1'b1, 4'h0, 8'h80, rd, er);
        do_op(1'b1, 4'h0, 8'h80, rd, er);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
        chk("lit_neg1", {24'd0, rd}, 32'hFF);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
`ifdef DPCM_SATURATION_EN
        chk("lit_neg_sat", {24'd0, rd}, 32'h80);
`else
        chk("lit_neg_wrap", {24'd0, rd}, 32'h7F);
`endif

        do_op(1'b1, 4'hC, 8'h01, rd, er);
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 4'h0, 8'd1, rd, er);
            chk("lit_fill_err", {31'd0, er}, (i == 4) ? 32'd1 : 32'd0);
        end
        do_op(1'b0, 4'h8, 8'h00, rd, er);
        chk("lit_status_full", {24'd0, rd}, 32'h42);
        for (int i = 1; i <= 4; i++) begin
            do_op(1'b0, 4'h4, 8'h00, rd, er);
            chk("lit_drain", {24'd0, rd}, i);
        end
        idle(1);

        do_op(1'b1, 4'h0, 8'd9, rd, er);
        do_op(1'b1, 4'h0, 8'd9, rd, er);
        do_op(1'b1, 4'hC, 8'h01, rd, er);
        do_op(1'b0, 4'h8, 8'h00, rd, er);
        chk("lit_clear_status", {24'd0, rd}, 32'h01);
        do_op(1'b1, 4'h0, 8'd5, rd, er);
        do_op(1'b0, 4'h4, 8'h00, rd, er);
        chk("lit_after_clear", {24'd0, rd}, 32'd5);
        idle(1);

        // Reset lands on the first access cycle of a DIFF write
        @(negedge clk);
        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite = 1'b1;
        bus.paddr = 4'h0;
        bus.pwdata = 8'd7;
        @(negedge clk);
        bus.penable = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_pready", {31'd0, bus.pready}, 32'd0);
        reset = 1'b0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        q.delete();
        pred = 0;
        idle(1);
        do_op(1'b0, 4'h8, 8'h00, rd, er);
        chk("lit_rst_mid_status", {24'd0, rd}, 32'h01);

        for (int n = 0; n < 300; n++) begin
            int          sel;
            logic        wr;
            logic [3:0]  a;
            logic [7:0]  wd;
            sel = int'($urandom_range(0, 99));
            wd  = 8'($urandom);
            a   = {2'b00, 2'($urandom)};
            if (sel < 40) begin
                wr = 1'b1;
                a[3:2] = 2'd0;
                if (sel < 8) wd = (sel < 4) ? 8'h7F : 8'h80;
            end else if (sel < 70) begin
                wr = 1'b0;
                a[3:2] = 2'd1;
            end else if (sel < 80) begin
                wr = 1'b0;
                a[3:2] = 2'd2;
            end else if (sel < 85) begin
                wr = 1'b1;
                a[3:2] = 2'd3;
            end else begin
                wr = 1'($urandom);
                a[3:2] = 2'($urandom);
            end
            do_op(wr, a, wd, rd, er);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
